// File: rtl/fixed_alu_pkg.sv
// Shared definitions for the sequential fixed-point ALU: op codes, FSM encoding
// and the two's-complement saturation limits.
package fixed_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_INV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_NORM = 2'b10
    } state_e;

    // Largest positive value of a width-bit two's-complement number.
    function automatic logic [63:0] max_pos(input int unsigned width);
        return (64'd1 << (width - 32'd1)) - 64'd1;
    endfunction

    // Magnitude of the most negative value; its low width bits are the 0x80..0 pattern.
    function automatic logic [63:0] min_neg(input int unsigned width);
        return 64'd1 << (width - 32'd1);
    endfunction

endpackage

// File: rtl/fixed_alu_seq_if.sv
// Request/response bundle between the operand registers and the fixed-point ALU.
interface fixed_alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output start, op, a, b,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/fixed_mul_iter.sv
// Unsigned shift-add multiplier core: load latches the operands, each step
// consumes one multiplier bit; after WIDTH steps prod_o holds the full product.
module fixed_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         step,
    input  logic [WIDTH-1:0]             mcand_i,
    input  logic [WIDTH-1:0]             mplier_i,
    output logic [$clog2(WIDTH+1)-1:0]   count_o,
    output logic [2*WIDTH-1:0]           prod_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Load clears the accumulator; a step adds the shifted multiplicand on the current bit.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, mcand_i};
            mplier_d = mplier_i;
            acc_d    = {PW{1'b0}};
            cnt_d    = {CW{1'b0}};
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end else begin
                acc_d = acc_q;
            end
            mcand_d  = {mcand_q[PW-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= {PW{1'b0}};
            acc_q    <= {PW{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign prod_o  = acc_q;
endmodule

// File: rtl/fixed_alu_seq.sv
// Sequential Q-format ALU: one-cycle add/sub/invalid path, iterative sign-magnitude
// multiply with truncating normalisation, and saturate-or-wrap overflow handling.
module fixed_alu_seq
    import fixed_alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    fixed_alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MAX_POS     = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MIN_NEG     = WIDTH'(min_neg(WIDTH));
    localparam logic [PW-1:0]    MAX_POS_EXT = PW'(max_pos(WIDTH));
    localparam logic [PW-1:0]    MIN_NEG_EXT = PW'(min_neg(WIDTH));
    localparam logic [WIDTH-1:0] ONE_W       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST_CNT    = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             sign_q, sign_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_res_q, pend_res_d;
    logic             pend_ovf_q, pend_ovf_d;

    op_e              op_s;
    logic [WIDTH:0]   ext_a_s, ext_b_s, addsub_s;
    logic [WIDTH-1:0] addsub_res_s;
    logic             addsub_ovf_s;
    logic [WIDTH-1:0] abs_a_s, abs_b_s;
    logic             mul_load_s, mul_step_s;
    logic [CW-1:0]    mul_cnt_s;
    logic [PW-1:0]    prod_s, mag_s;
    logic [WIDTH-1:0] neg_s, norm_res_s;
    logic             norm_ovf_s;

    fixed_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (mul_load_s),
        .step     (mul_step_s),
        .mcand_i  (abs_a_s),
        .mplier_i (abs_b_s),
        .count_o  (mul_cnt_s),
        .prod_o   (prod_s)
    );

    // Add/sub one bit wider than the operands so the true result is always representable.
    always_comb begin
        op_s    = op_e'(bus.op);
        ext_a_s = {bus.a[WIDTH-1], bus.a};
        ext_b_s = {bus.b[WIDTH-1], bus.b};
        if (op_s == OP_SUB) begin
            addsub_s = ext_a_s - ext_b_s;
        end else begin
            addsub_s = ext_a_s + ext_b_s;
        end
        addsub_ovf_s = addsub_s[WIDTH] ^ addsub_s[WIDTH-1];
        if (addsub_ovf_s && SATURATE) begin
            addsub_res_s = addsub_s[WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            addsub_res_s = addsub_s[WIDTH-1:0];
        end
        abs_a_s = bus.a[WIDTH-1] ? (~bus.a + ONE_W) : bus.a;
        abs_b_s = bus.b[WIDTH-1] ? (~bus.b + ONE_W) : bus.b;
    end

    // Truncating the magnitude before re-applying the sign rounds toward zero.
    always_comb begin
        mag_s = prod_s >> FRAC;
        neg_s = ~mag_s[WIDTH-1:0] + ONE_W;
        if (sign_q) begin
            norm_ovf_s = (mag_s > MIN_NEG_EXT);
            if (norm_ovf_s && SATURATE) begin
                norm_res_s = MIN_NEG;
            end else begin
                norm_res_s = neg_s;
            end
        end else begin
            norm_ovf_s = (mag_s > MAX_POS_EXT);
            if (norm_ovf_s && SATURATE) begin
                norm_res_s = MAX_POS;
            end else begin
                norm_res_s = mag_s[WIDTH-1:0];
            end
        end
    end

    // Controller: single-cycle ops go through a one-deep pending stage, mul walks MUL/NORM.
    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        done_d     = 1'b0;
        result_d   = result_q;
        overflow_d = overflow_q;
        pend_d     = 1'b0;
        pend_res_d = pend_res_q;
        pend_ovf_d = pend_ovf_q;
        mul_load_s = 1'b0;
        mul_step_s = 1'b0;
        if (pend_q) begin
            done_d     = 1'b1;
            result_d   = pend_res_q;
            overflow_d = pend_ovf_q;
        end else begin
            done_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (op_s)
                        OP_ADD, OP_SUB: begin
                            pend_d     = 1'b1;
                            pend_res_d = addsub_res_s;
                            pend_ovf_d = addsub_ovf_s;
                        end
                        OP_MUL: begin
                            mul_load_s = 1'b1;
                            sign_d     = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            state_d    = ST_MUL;
                        end
                        default: begin
                            pend_d     = 1'b1;
                            pend_res_d = {WIDTH{1'b0}};
                            pend_ovf_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                mul_step_s = 1'b1;
                if (mul_cnt_s == LAST_CNT) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_NORM: begin
                done_d     = 1'b1;
                result_d   = norm_res_s;
                overflow_d = norm_ovf_s;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sign_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= {WIDTH{1'b0}};
            overflow_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_res_q <= {WIDTH{1'b0}};
            pend_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            pend_q     <= pend_d;
            pend_res_q <= pend_res_d;
            pend_ovf_q <= pend_ovf_d;
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_fixed_alu_seq.sv
// Bench for fixed_alu_seq: a saturating and a wrapping instance share one stimulus
// stream and are compared against an integer-arithmetic reference model.
module tb_fixed_alu_seq;
    localparam int W       = 16;
    localparam int F       = 8;
    localparam int MUL_LAT = W + 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fixed_alu_seq_if #(.WIDTH(W)) bus0 ();
    fixed_alu_seq_if #(.WIDTH(W)) bus1 ();

    fixed_alu_seq #(.WIDTH(W), .FRAC(F), .SATURATE(1'b1)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    fixed_alu_seq #(.WIDTH(W), .FRAC(F), .SATURATE(1'b0)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, then range check and clamp or wrap.
    function automatic void ref_model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                      input bit sat, output logic [15:0] res, output logic ovf);
        longint sa, sb, t, p, mag;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        t  = 0;
        case (o)
            2'd0: t = sa + sb;
            2'd1: t = sa - sb;
            2'd2: begin
                p   = sa * sb;
                mag = ((p < 0) ? -p : p) / longint'(2 ** F);
                t   = (p < 0) ? -mag : mag;
            end
            default: begin
                res = 16'h0000;
                ovf = 1'b1;
                return;
            end
        endcase
        ovf = (t > 32767) || (t < -32768);
        if (ovf && sat) res = (t > 0) ? 16'h7FFF : 16'h8000;
        else            res = t[15:0];
    endfunction

    task automatic check_v(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        bus0.start = s; bus0.op = o; bus0.a = x; bus0.b = y;
        bus1.start = s; bus1.op = o; bus1.a = x; bus1.b = y;
    endtask

    // Present a request, let the next edge accept it, then scramble the operand lines.
    task automatic begin_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        drive(1'b1, o, x, y);
        @(posedge clk);
        #1;
        drive(1'b0, 2'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus0.done !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input string tag);
        logic [15:0] r0, r1;
        logic        v0, v1;
        int          lat;
        ref_model(o, x, y, 1'b1, r0, v0);
        ref_model(o, x, y, 1'b0, r1, v1);
        begin_op(o, x, y);
        check_b({tag, "_busy"}, bus0.busy, (o == 2'd2));
        wait_done(lat);
        check_i({tag, "_lat"}, lat, (o == 2'd2) ? MUL_LAT : 1);
        check_v({tag, "_res"}, bus0.result, r0);
        check_b({tag, "_ovf"}, bus0.overflow, v0);
        check_b({tag, "_wdone"}, bus1.done, 1'b1);
        check_v({tag, "_wres"}, bus1.result, r1);
        check_b({tag, "_wovf"}, bus1.overflow, v1);
        check_b({tag, "_idle"}, bus0.busy, 1'b0);
        @(posedge clk);
        #1;
        check_b({tag, "_pulse"}, bus0.done, 1'b0);
    endtask

    logic [1:0]  ro;
    logic [15:0] ra, rb, er;
    logic        ev;
    logic [1:0]  bo [3];
    logic [15:0] ba [3];
    logic [15:0] bb [3];
    int          lat;
    int          dcnt;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 2'd0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        check_b("rst_busy", bus0.busy, 1'b0);
        check_b("rst_done", bus0.done, 1'b0);
        check_v("rst_res", bus0.result, 16'h0000);
        check_b("rst_ovf", bus0.overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'd0, 16'd27, 16'd42, "add_27_42");
        check_v("add_lit", bus0.result, 16'd69);
        run_op(2'd2, 16'h0180, 16'h0200, "mul_1p5x2");
        check_v("mul_lit", bus0.result, 16'h0300);
        run_op(2'd2, 16'hFF00, 16'h0080, "mul_m1xhalf");
        check_v("mul_neg_lit", bus0.result, 16'hFF80);
        run_op(2'd0, 16'h7FFF, 16'h0001, "add_ovf");
        check_v("add_wrap_lit", bus1.result, 16'h8000);
        run_op(2'd2, 16'h4000, 16'h0400, "mul_ovf");
        run_op(2'd2, 16'h8000, 16'h0100, "mul_minneg");
        run_op(2'd3, 16'h1234, 16'h5678, "inv");
        run_op(2'd1, 16'h0000, 16'h8000, "sub_ovf");
        check_v("sub_lit", bus0.result, 16'h7FFF);

        repeat (40) begin
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 1) == 1) ra = {{6{ra[9]}}, ra[9:0]};
            if ($urandom_range(0, 1) == 1) rb = {{6{rb[9]}}, rb[9:0]};
            run_op(ro, ra, rb, $sformatf("rnd_op%0d", ro));
        end

        // Start mid-multiply must be ignored.
        begin_op(2'd2, 16'hFF00, 16'h0080);
        repeat (4) begin @(posedge clk); #1; end
        drive(1'b1, 2'd0, 16'h1111, 16'h2222);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 16'd0, 16'd0);
        wait_done(lat);
        check_i("mid_lat", lat, MUL_LAT - 5);
        ref_model(2'd2, 16'hFF00, 16'h0080, 1'b1, er, ev);
        check_v("mid_res", bus0.result, er);
        @(posedge clk);
        #1;
        check_b("mid_nodone1", bus0.done, 1'b0);
        @(posedge clk);
        #1;
        check_b("mid_nodone2", bus0.done, 1'b0);

        // New request on the done cycle.
        begin_op(2'd2, 16'h0180, 16'h0200);
        wait_done(lat);
        check_i("b2b_mul_lat", lat, MUL_LAT);
        check_v("b2b_mul_res", bus0.result, 16'h0300);
        drive(1'b1, 2'd0, 16'd27, 16'd42);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 16'd0, 16'd0);
        check_b("b2b_gap", bus0.done, 1'b0);
        @(posedge clk);
        #1;
        check_b("b2b_add_done", bus0.done, 1'b1);
        check_v("b2b_add_res", bus0.result, 16'd69);

        // One single-cycle op per clock.
        for (int i = 0; i < 3; i++) begin
            bo[i] = 2'($urandom_range(0, 1));
            ba[i] = 16'($urandom);
            bb[i] = 16'($urandom);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, bo[i], ba[i], bb[i]);
            else       drive(1'b0, 2'd0, 16'd0, 16'd0);
            @(posedge clk);
            #1;
            if (i >= 1 && i <= 3) begin
                ref_model(bo[i-1], ba[i-1], bb[i-1], 1'b1, er, ev);
                check_b($sformatf("tput%0d_done", i), bus0.done, 1'b1);
                check_v($sformatf("tput%0d_res", i), bus0.result, er);
                check_b($sformatf("tput%0d_ovf", i), bus0.overflow, ev);
            end else begin
                check_b($sformatf("tput%0d_idle", i), bus0.done, 1'b0);
            end
        end

        // Reset during MUL aborts the operation.
        begin_op(2'd2, 16'h0180, 16'h0200);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_b("rstmid_busy", bus0.busy, 1'b0);
        check_b("rstmid_done", bus0.done, 1'b0);
        check_v("rstmid_res", bus0.result, 16'h0000);
        check_b("rstmid_ovf", bus0.overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus0.done === 1'b1) dcnt++;
        end
        check_i("rstmid_nodone", dcnt, 0);
        run_op(2'd2, 16'h0180, 16'h0200, "post_rst_mul");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fixed_alu_seq.md
# fixed_alu_seq

Parametrised sequential fixed-point arithmetic unit, the successor to the combinational 16-bit fixed adder/multiplier pair. It executes add, sub or mul on two's-complement Q-format operands of configurable width. It uses a start/busy/done handshake, a single-cycle add/sub path and an iterative shift-add multiplier. Overflow is either saturated or wrapped, set by parameter. It sits between the operand registers of the operator core and the display/result path.

## Interface
- WIDTH, 16: operand/result width in bits, 4..32.
- FRAC, 8: fraction bits of the Q format, 0..WIDTH-1.
- SATURATE, 1: 1 = clamp to max/min on overflow; 0 = wrap (keep low WIDTH bits).
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- op  input  2  00 add, 01 sub (a-b), 10 mul, 11 invalid.
- a  input  WIDTH  operand A, two's complement Q(WIDTH-FRAC).FRAC.
- b  input  WIDTH  operand B, same format.
- busy  output  1  high while a mul is in progress.
- done  output  1  one-cycle pulse, result/overflow valid.
- result  output  WIDTH  last result; held until the next done.
- overflow  output  1  overflow/invalid flag of last operation; held with result.

## Operation
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, result=0, overflow=0, counter=0. Reset mid-mul aborts the operation; no done is produced.
- States: IDLE, MUL, NORM.
- IDLE, start=1, op=00/01: compute a+b or a-b at WIDTH+1 bits. The next edge registers result and overflow, pulses done, and stays in IDLE.
- Add/sub overflow: the true sum is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SATURATE=1: result clamps to 0x7F..F (positive) or 0x80..0 (negative).
  - SATURATE=0: result is the low WIDTH bits.
- IDLE, start=1, op=10: latch sign = a[MSB]^b[MSB] and unsigned magnitudes |a| and |b|. Magnitudes are WIDTH bits, so |min| = 2^(WIDTH-1) is exact. Go to MUL with counter=0 and the 2WIDTH-bit accumulator cleared.
- MUL: each cycle, conditionally add the shifted multiplicand on the current multiplier bit and increment the counter. After WIDTH iterations, go to NORM.
- NORM: shift the accumulator right by FRAC. This truncates the magnitude, so rounding is toward zero. Apply sign.
  - Overflow when the magnitude exceeds 2^(WIDTH-1)-1 for a positive result or 2^(WIDTH-1) for a negative result. Saturate or wrap as for add.
  - The next edge registers result and overflow, pulses done, and returns to IDLE.
- op=11: done after 1 cycle, result=0, overflow=1.
- start while busy=1 is ignored; there is no queueing.
- start in the same cycle done=1 is accepted, allowing back-to-back operations.
- a, b and op are sampled only on the accepting edge. Later changes do not affect the operation in flight.

## Timing
- busy = (state != IDLE), a registered-state decode.
- Add/sub/invalid: start accepted at edge k, done=1 for the cycle after edge k+1. Latency 1 clock; throughput 1 operation per clock.
- Mul: start accepted at edge k; MUL occupies edges k+1..k+WIDTH; NORM at edge k+WIDTH+1. done=1 for the cycle after edge k+WIDTH+1.
  - Latency WIDTH+1 clocks (17 at the defaults).
  - busy is high from after edge k until the edge that raises done.
- done is exactly one cycle wide. result and overflow change only on the edge that raises done.

## Structure
- Shared package fixed_alu_pkg holds:
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_INV;
  - the state encoding;
  - the saturation-limit functions max_pos(WIDTH) and min_neg(WIDTH).
- One sub-module, fixed_mul_iter: the unsigned shift-add core with load/step/count and a 2WIDTH-bit product output. The top holds the FSM, sign handling, add/sub, normalisation and saturation.

## Test plan
- WIDTH=16, FRAC=8, SATURATE=1: add a=27, b=42 -> done 1 cycle later, result=69, overflow=0.
- mul a=0x0180 (1.5), b=0x0200 (2.0) -> busy for 17 cycles, done then result=0x0300, overflow=0. mul 0xFF00 (-1.0) × 0x0080 (0.5) -> 0xFF80.
- Overflow:
  - add 0x7FFF+0x0001 -> 0x7FFF, overflow=1; with SATURATE=0 -> 0x8000, overflow=1.
  - mul 0x4000×0x0400 (64×4) -> 0x7FFF, overflow=1.
  - mul 0x8000×0x0100 (-128×1) -> 0x8000, overflow=0.
- Start mid-mul with op=00 and new operands -> ignored; mul result unchanged. start asserted on the done cycle -> new op accepted; its done arrives at the expected latency.
- rst_n low at MUL cycle 5 -> busy=0, done never pulses, result=0, overflow=0. A new mul after release completes normally.
- op=11 -> done after 1 cycle, result=0, overflow=1. Sub 0x0000-0x8000 -> 0x7FFF, overflow=1.
